// File: rtl/shift_ctrl_if.sv
// Handshake and operand bundle between the issue stage, the shift sequencer
// and the barrel shifter.
interface shift_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [31:0] rm_data;
    logic        c_flag;
    logic        rs_req;
    logic [3:0]  rs_addr;
    logic [31:0] rs_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op1;
    logic [7:0]  shift_amount;
    logic [2:0]  shift_type;
    logic        c_in;

    modport master (
        output in_valid, inst, rm_data, c_flag, rs_data, out_ready,
        input  in_ready, rs_req, rs_addr, out_valid, op1, shift_amount, shift_type, c_in
    );

    modport slave (
        input  in_valid, inst, rm_data, c_flag, rs_data, out_ready,
        output in_ready, rs_req, rs_addr, out_valid, op1, shift_amount, shift_type, c_in
    );
endinterface

// File: rtl/shift_ctrl.sv
// Operand-2 sequencer: decodes the ARM shifter-operand field and drives
// registered barrel-shifter operands, spending one extra cycle to read Rs.
module shift_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    shift_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RS    = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state;
    logic        accept;
    logic        dec_reg;
    logic [31:0] dec_op1;
    logic [7:0]  dec_amt;
    logic [2:0]  dec_type;
    logic        unused_bits;

    assign bus.in_ready = (state == IDLE) || (state == VALID && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign unused_bits  = ^{bus.inst[31:26], bus.inst[24:12], bus.rs_data[31:8]};

    always_comb begin
        dec_reg  = 1'b0;
        dec_op1  = bus.rm_data;
        dec_amt  = 8'h00;
        dec_type = 3'b000;
        if (bus.inst[25]) begin
            dec_op1  = {24'h0, bus.inst[7:0]};
            dec_amt  = {3'b000, bus.inst[11:8], 1'b0};
            dec_type = 3'b011;
        end else if (bus.inst[4]) begin
            dec_reg  = 1'b1;
            dec_type = {1'b0, bus.inst[6:5]};
        end else begin
            dec_amt  = {3'b000, bus.inst[11:7]};
            dec_type = {1'b1, bus.inst[6:5]};
        end
    end

    // A register-specified shift leaves shift_amount alone until Rs arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            bus.out_valid    <= 1'b0;
            bus.rs_req       <= 1'b0;
            bus.rs_addr      <= 4'h0;
            bus.op1          <= 32'h0;
            bus.shift_amount <= 8'h00;
            bus.shift_type   <= 3'b000;
            bus.c_in         <= 1'b0;
        end else if (flush) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.rs_req    <= 1'b0;
        end else if (accept) begin
            bus.op1        <= dec_op1;
            bus.shift_type <= dec_type;
            bus.c_in       <= bus.c_flag;
            bus.rs_addr    <= bus.inst[11:8];
            if (dec_reg) begin
                state         <= RS;
                bus.rs_req    <= 1'b1;
                bus.out_valid <= 1'b0;
            end else begin
                bus.shift_amount <= dec_amt;
                state            <= VALID;
                bus.rs_req       <= 1'b0;
                bus.out_valid    <= 1'b1;
            end
        end else begin
            case (state)
                RS: begin
                    bus.shift_amount <= bus.rs_data[7:0];
                    state            <= VALID;
                    bus.rs_req       <= 1'b0;
                    bus.out_valid    <= 1'b1;
                end
                VALID: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_ctrl.sv
// Bench for shift_ctrl: directed steps from the operand-2 rules followed by
// random traffic scored against a transaction-level timing/decode model.
module tb_shift_ctrl;
    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    shift_ctrl_if bus();

    shift_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          have;
        bit          is_reg;
        int          avail;
        logic [31:0] op1;
        logic [7:0]  amt;
        logic [2:0]  typ;
        logic        cin;
        logic [3:0]  rsa;
    } item_t;

    item_t held;

    // Expected operands of one instruction, straight from the ARM operand-2 rules.
    function automatic item_t predict(input logic [31:0] i, input logic [31:0] rm,
                                      input logic c, input int now);
        item_t p;
        p.have   = 1'b1;
        p.is_reg = (i[25] == 1'b0) && (i[4] == 1'b1);
        p.cin    = c;
        p.rsa    = 4'((i >> 8) % 16);
        if (i[25]) begin
            p.op1 = i % 256;
            p.amt = 8'(((i >> 8) % 16) * 2);
            p.typ = 3'd3;
        end else begin
            p.op1 = rm;
            p.typ = 3'(((i >> 5) % 4) + (p.is_reg ? 0 : 4));
            p.amt = p.is_reg ? 8'd0 : 8'((i >> 7) % 32);
        end
        p.avail = now + (p.is_reg ? 2 : 1);
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs, scores outputs against the model, then clocks.
    task automatic applyStimulus(input logic v, input logic [31:0] i, input logic [31:0] rm,
                                 input logic c, input logic [31:0] rs, input logic ordy,
                                 input logic fl);
        bit vexp, rsexp, rdyexp;
        bus.in_valid  = v;
        bus.inst      = i;
        bus.rm_data   = rm;
        bus.c_flag    = c;
        bus.rs_data   = rs;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        if (reset) begin
            held.have = 1'b0;
        end else begin
            vexp   = held.have && (cyc >= held.avail);
            rsexp  = held.have && held.is_reg && (cyc == held.avail - 1);
            rdyexp = !held.have || (vexp && ordy);
            checkOutput("out_valid", 32'(bus.out_valid), 32'(vexp));
            checkOutput("rs_req", 32'(bus.rs_req), 32'(rsexp));
            checkOutput("in_ready", 32'(bus.in_ready), 32'(rdyexp));
            if (vexp) begin
                checkOutput("op1", bus.op1, held.op1);
                checkOutput("shift_amount", 32'(bus.shift_amount), 32'(held.amt));
                checkOutput("shift_type", 32'(bus.shift_type), 32'(held.typ));
                checkOutput("c_in", 32'(bus.c_in), 32'(held.cin));
            end
            if (rsexp) checkOutput("rs_addr", 32'(bus.rs_addr), 32'(held.rsa));
            if (fl) begin
                held.have = 1'b0;
            end else begin
                if (rsexp) held.amt = rs[7:0];
                if (vexp && ordy) held.have = 1'b0;
                if (v && rdyexp) held = predict(i, rm, c, cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        held.have = 1'b0;
        reset     = 1'b1;

        $display("[TB] reset with in_valid held high");
        applyStimulus(1'b1, 32'hE3A00F3F, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hE3A00F3F, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_rs_req", 32'(bus.rs_req), 32'd0);
        checkOutput("rst_rs_addr", 32'(bus.rs_addr), 32'd0);
        checkOutput("rst_op1", bus.op1, 32'd0);
        checkOutput("rst_amt", 32'(bus.shift_amount), 32'd0);
        checkOutput("rst_type", 32'(bus.shift_type), 32'd0);
        checkOutput("rst_c_in", 32'(bus.c_in), 32'd0);

        $display("[TB] immediate and shift-by-immediate");
        applyStimulus(1'b1, 32'hE3A00F3F, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        checkOutput("imm_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("imm_op1", bus.op1, 32'h0000003F);
        checkOutput("imm_amt", 32'(bus.shift_amount), 32'h1E);
        checkOutput("imm_type", 32'(bus.shift_type), 32'd3);
        checkOutput("imm_c_in", 32'(bus.c_in), 32'd1);
        applyStimulus(1'b1, 32'hE1A00221, 32'h80000010, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("lsr4_op1", bus.op1, 32'h80000010);
        checkOutput("lsr4_amt", 32'(bus.shift_amount), 32'h04);
        checkOutput("lsr4_type", 32'(bus.shift_type), 32'd5);
        applyStimulus(1'b1, 32'hE1A00061, 32'h12345678, 1'b1, 32'h0, 1'b1, 1'b0);
        checkOutput("rrx_amt", 32'(bus.shift_amount), 32'h00);
        checkOutput("rrx_type", 32'(bus.shift_type), 32'd7);

        $display("[TB] shift-by-register");
        applyStimulus(1'b1, 32'hE1A00251, 32'hF0000000, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("reg_rs_req", 32'(bus.rs_req), 32'd1);
        checkOutput("reg_rs_addr", 32'(bus.rs_addr), 32'd2);
        checkOutput("reg_in_ready", 32'(bus.in_ready), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h00000121, 1'b0, 1'b0);
        checkOutput("reg_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("reg_amt", 32'(bus.shift_amount), 32'h21);
        checkOutput("reg_type", 32'(bus.shift_type), 32'd2);
        checkOutput("reg_op1", bus.op1, 32'hF0000000);

        $display("[TB] stall then back-to-back hand-off");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 32'hE3A00101, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
            checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("stall_op1", bus.op1, 32'hF0000000);
        end
        applyStimulus(1'b1, 32'hE3A00101, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        checkOutput("b2b_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("b2b_op1", bus.op1, 32'h00000001);
        checkOutput("b2b_amt", 32'(bus.shift_amount), 32'h02);

        $display("[TB] flush in RS and in VALID");
        applyStimulus(1'b1, 32'hE1A00351, 32'hAAAA5555, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("frs_rs_req", 32'(bus.rs_req), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h55, 1'b1, 1'b1);
        checkOutput("frs_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("frs_rs_req_drop", 32'(bus.rs_req), 32'd0);
        checkOutput("frs_in_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b1, 32'hE3A000AA, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hE3A000BB, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
        checkOutput("fv_out_valid", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("fv_still_idle", 32'(bus.out_valid), 32'd0);
        checkOutput("fv_op1_kept", bus.op1, 32'h000000AA);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom_range(0, 1)),
                          $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_ctrl.md
# shift_ctrl

Operand-2 sequencer for the ARM9 execute stage. It decodes the shifter-operand field of a data-processing instruction and produces registered drive for the barrel shifter inputs: op1, shift_amount, shift_type and carry-in. Register-specified shifts take a second cycle to read Rs through a register-file port. A valid/ready handshake toward the shifter/ALU stage lets that stage stall the sequencer.

## Interface
- No parameters; all widths fixed by the ARM operand-2 encoding.
- clk  input  1  single core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous pipeline flush; discards any instruction in flight
- in_valid  input  1  inst/rm_data/c_flag valid this cycle
- in_ready  output  1  sequencer accepts on in_valid && in_ready
- inst  input  32  instruction word (only [25], [11:0] used)
- rm_data  input  32  value of Rm, sampled at acceptance
- c_flag  input  1  current CPSR C, sampled at acceptance
- rs_req  output  1  request read of Rs this cycle
- rs_addr  output  4  Rs register index (inst[11:8] of held instruction)
- rs_data  input  32  Rs value, valid in the same cycle as rs_req; only [7:0] used
- out_valid  output  1  shifter operands valid
- out_ready  input  1  downstream consumes on out_valid && out_ready
- op1  output  32  shifter operand
- shift_amount  output  8  shift count
- shift_type  output  3  [1:0] LSL/LSR/ASR/ROR = 00/01/10/11; [2]=1 marks shift-by-immediate
- c_in  output  1  carry passed to shifter

## Operation
- Decode at acceptance:
  - Immediate (inst[25]=1): op1={24'h0,inst[7:0]}, shift_amount={3'b000,inst[11:8],1'b0}, shift_type=3'b011. With zero rotate the shifter passes C through.
  - Shift by immediate (inst[25]=0, inst[4]=0): op1=rm_data, shift_amount={3'b000,inst[11:7]}, shift_type={1'b1,inst[6:5]}. An amount of 0 therefore encodes LSR#32, ASR#32 or RRX in the shifter.
  - Shift by register (inst[25]=0, inst[4]=1): op1=rm_data, shift_type={1'b0,inst[6:5]}, shift_amount=rs_data[7:0] captured in the RS state.
- c_in = c_flag sampled at acceptance, for all forms.
- States:
  - IDLE: in_ready=1.
    - Accept of immediate / shift-by-immediate -> VALID.
    - Accept of shift-by-register -> RS.
  - RS: rs_req=1, in_ready=0, out_valid=0; capture rs_data[7:0] into shift_amount -> VALID.
  - VALID: out_valid=1; all operand outputs held stable while out_ready=0.
    - On out_ready: new accept follows the IDLE rules; no accept -> IDLE.
- in_ready = (state==IDLE) || (state==VALID && out_ready). Back-to-back accept in the hand-off cycle is required.
- Operand registers load only on accept (and shift_amount in RS). They are unchanged otherwise.
- rs_addr is driven from the held inst[11:8] in every state; it is only meaningful while rs_req=1.
- flush: next state IDLE and out_valid=0; any accept or RS capture in that cycle is dropped. in_ready remains a function of the current state.
- Priority: reset > flush > normal operation.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, rs_req=0.
  - rs_addr=0, op1=0, shift_amount=0, shift_type=0, c_in=0.
- Latency from accept edge to out_valid:
  - 1 cycle for immediate and shift-by-immediate.
  - 2 cycles for shift-by-register (RS occupies one cycle).
- Throughput is 1 instruction/cycle for non-register shifts with out_ready held high. Each register shift inserts one bubble.
- Outputs are registered with no combinational path from inputs, except in_ready from out_ready.
- Reset or flush while in RS: rs_req drops the next cycle and the held instruction is lost.

## Test plan
- Reset: assert reset 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, rs_req=0 and all operand outputs 0 after release.
- Immediate path:
  - Stimulus: inst=0xE3A00F3F, c_flag=1, out_ready=1.
  - Required: next cycle out_valid=1, op1=0x0000003F, shift_amount=0x1E, shift_type=3'b011, c_in=1.
- Shift-by-immediate:
  - inst=0xE1A00221, rm_data=0x80000010 -> op1=0x80000010, shift_amount=0x04, shift_type=3'b101.
  - inst=0xE1A00061 -> shift_type=3'b111, shift_amount=0x00 (RRX).
- Shift-by-register:
  - Stimulus: inst=0xE1A00251, rm_data=0xF0000000, rs_data=0x00000121.
  - Required: cycle after accept rs_req=1, rs_addr=2, in_ready=0; following cycle out_valid=1, shift_amount=0x21, shift_type=3'b010.
- Stall/back-to-back:
  - Hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0.
  - Raise out_ready -> second instruction accepted in the same cycle; its operands appear the next cycle.
- Flush:
  - Assert flush in the RS cycle -> next cycle state IDLE, out_valid=0, rs_req=0.
  - Assert flush in VALID with in_valid=1 -> no new instruction captured.
